axi_sram_slave: RTL and testbench

- AXI4 memory-side responder: the slave end of the CPU's AXI master port (aw/w/b/ar/r channels).
- Backs the port with an internal word-addressed SRAM array.
- Used as the on-chip/simulation memory for the ysyx_22040127 core, replacing DPI pmem access.
- Independent read and write engines; FIXED and INCR bursts, lengths 1–256.

---
 rtl/axi_sram_pkg.sv | 16 +
 rtl/axi_sram_slave_if.sv | 64 ++++++
 rtl/axi_sram_array.sv | 39 +++
 rtl/axi_sram_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_pkg.sv
// Shared definitions for the AXI4 SRAM responder: response and burst
// encodings plus the read/write engine state types.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 aw/w/b/ar/r channel bundle between the CPU master and the SRAM
// responder.
//   slave  modport : responder view (address/data in, ready/response out)
//   master modport : CPU view
interface axi_sram_slave_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                    aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid, w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid, b_ready;
  logic [1:0]              b_resp;
  logic [ID_WIDTH-1:0]     b_id;

  logic                    ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid, r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [ID_WIDTH-1:0]     r_id;

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready
  );
endinterface

// File: rtl/axi_sram_array.sv
// Word-addressed SRAM, 2**DEPTH_LOG2 x DATA_WIDTH.
//   clk          clock
//   re/raddr     read enable/index; rdata is registered and holds when re=0
//   we/waddr     write enable/index
//   wstrb/wdata  byte enables and write data
// A read and a write to the same word in one cycle returns the old word.
// Contents are not reset.
module axi_sram_array #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata
);
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we)
      for (int i = 0; i < LANES; i++)
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 memory-side responder backed by an internal SRAM (axi_sram_array).
//   clk, rst  clock, synchronous active-high reset
//   s         AXI slave port (aw/w/b/ar/r)
// Independent read and write engines, one burst each in flight. FIXED and
// INCR bursts of 1..256 beats; errors are decided at the address handshake.
// Build option: AXI_SLAVE_RD_WAIT_EN inserts RD_LATENCY idle cycles before
// every read beat.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(64'h8000_0000),
  parameter int                    RD_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  axi_sram_slave_if.slave s
);
  localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
  // decoded window size in bytes
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(1) << (DEPTH_LOG2 + OFF_BITS);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            len;
    logic [7:0]            cnt;
    logic [2:0]            size;
    logic                  fixed;  // address held between beats
    logic [1:0]            resp;
  } burst_t;

  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] a);
    return idx_t'((a - BASE_ADDR) >> OFF_BITS);
  endfunction

  function automatic burst_t burst_start(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic [ID_WIDTH-1:0] id,
                                         input logic [7:0] len,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
    burst_t b;
    b.addr = addr;
    b.id   = id;
    b.len  = len;
    b.cnt  = '0;
    b.size = size;
    if (addr < BASE_ADDR || (addr - BASE_ADDR) >= SPAN)
      b.resp = RESP_DECERR;
    else if (size > 3'(OFF_BITS) || burst == BURST_WRAP || burst == 2'b11)
      b.resp = RESP_SLVERR;
    else
      b.resp = RESP_OKAY;
    // SLVERR bursts walk the address as INCR regardless of type
    b.fixed = (burst == BURST_FIXED) && (b.resp != RESP_SLVERR);
    return b;
  endfunction

  function automatic burst_t burst_step(input burst_t b);
    burst_t n;
    n     = b;
    n.cnt = b.cnt + 8'd1;
    if (!b.fixed) n.addr = b.addr + (ADDR_WIDTH'(1) << b.size);
    return n;
  endfunction

  // ---------------- read engine ----------------
  rd_state_t             rd_state_q, rd_state_d;
  burst_t                rd_q, rd_d;
  logic                  r_valid_q, r_valid_d;
  logic                  rd_fetch;
  logic [ADDR_WIDTH-1:0] rd_fetch_addr;
  logic [DATA_WIDTH-1:0] arr_rdata;
`ifdef AXI_SLAVE_RD_WAIT_EN
  logic [7:0]            r_wait_q, r_wait_d;
`endif

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_d          = rd_q;
    r_valid_d     = r_valid_q;
    rd_fetch      = 1'b0;
    rd_fetch_addr = rd_q.addr;
`ifdef AXI_SLAVE_RD_WAIT_EN
    r_wait_d      = r_wait_q;
`endif
    case (rd_state_q)
      R_IDLE: if (s.ar_valid) begin
        rd_d          = burst_start(s.ar_addr, s.ar_id, s.ar_len, s.ar_size, s.ar_burst);
        rd_fetch      = 1'b1;
        rd_fetch_addr = s.ar_addr;
        rd_state_d    = R_DATA;
      end
      R_DATA: begin
`ifdef AXI_SLAVE_RD_WAIT_EN
        if (r_wait_q != 8'd0) begin
          r_wait_d = r_wait_q - 8'd1;
          if (r_wait_q == 8'd1) r_valid_d = 1'b1;
        end
`endif
        if (r_valid_q && s.r_ready) begin
          if (rd_q.cnt == rd_q.len) begin
            rd_state_d = R_IDLE;
            r_valid_d  = 1'b0;
          end else begin
            rd_d          = burst_step(rd_q);
            rd_fetch      = 1'b1;
            rd_fetch_addr = rd_d.addr;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    // each fetch lands in the array's output register next cycle
    if (rd_fetch) begin
`ifdef AXI_SLAVE_RD_WAIT_EN
      if (RD_LATENCY == 0) r_valid_d = 1'b1;
      else begin
        r_valid_d = 1'b0;
        r_wait_d  = 8'(RD_LATENCY);
      end
`else
      r_valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_q       <= '0;
      r_valid_q  <= 1'b0;
`ifdef AXI_SLAVE_RD_WAIT_EN
      r_wait_q   <= 8'd0;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      rd_q       <= rd_d;
      r_valid_q  <= r_valid_d;
`ifdef AXI_SLAVE_RD_WAIT_EN
      r_wait_q   <= r_wait_d;
`endif
    end
  end

  assign s.ar_ready = (rd_state_q == R_IDLE) && !rst;
  assign s.r_valid  = r_valid_q;
  assign s.r_data   = (r_valid_q && rd_q.resp != RESP_DECERR) ? arr_rdata : '0;
  assign s.r_last   = r_valid_q && (rd_q.cnt == rd_q.len);
  assign s.r_resp   = rd_q.resp;
  assign s.r_id     = rd_q.id;

  // ---------------- write engine ----------------
  wr_state_t wr_state_q, wr_state_d;
  burst_t    wr_q, wr_d, wr_nxt;
  logic      arr_we;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_d       = wr_q;
    wr_nxt     = burst_step(wr_q);
    arr_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: if (s.aw_valid) begin
        wr_d       = burst_start(s.aw_addr, s.aw_id, s.aw_len, s.aw_size, s.aw_burst);
        wr_state_d = W_DATA;
      end
      W_DATA: if (s.w_valid) begin
        arr_we = (wr_q.resp == RESP_OKAY);
        if ((s.w_last != (wr_q.cnt == wr_q.len)) && wr_q.resp != RESP_DECERR)
          wr_d.resp = RESP_SLVERR;
        // the beat count, not w_last, closes the data phase
        if (wr_q.cnt == wr_q.len) wr_state_d = W_RESP;
        else begin
          wr_d.addr = wr_nxt.addr;
          wr_d.cnt  = wr_nxt.cnt;
        end
      end
      W_RESP: if (s.b_ready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_q       <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_q       <= wr_d;
    end
  end

  assign s.aw_ready = (wr_state_q == W_IDLE) && !rst;
  assign s.w_ready  = (wr_state_q == W_DATA);
  assign s.b_valid  = (wr_state_q == W_RESP);
  assign s.b_resp   = wr_q.resp;
  assign s.b_id     = wr_q.id;

  // ---------------- storage ----------------
  idx_t arr_raddr, arr_waddr;
  assign arr_raddr = word_idx(rd_fetch_addr);
  assign arr_waddr = word_idx(wr_q.addr);

  axi_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .re   (rd_fetch),
    .raddr(arr_raddr),
    .rdata(arr_rdata),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wstrb(s.w_strb),
    .wdata(s.w_data)
  );
endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int          AW    = 64;
  localparam int          DW    = 64;
  localparam int          IW    = 4;
  localparam int          DL2   = 12;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

  axi_sram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH_LOG2(DL2),
    .BASE_ADDR(BASE), .RD_LATENCY(LAT)
  ) dut (.clk(clk), .rst(rst), .s(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mem_m [DEPTH];

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  rexp_t      rq[$];
  logic [5:0] bq[$];  // {id, resp}

  function automatic logic [1:0] m_resp(input logic [63:0] a, input logic [2:0] size,
                                        input logic [1:0] burst);
    if (a < BASE || a >= BASE + 64'(DEPTH * 8)) return 2'b11;
    if (size > 3'd3 || burst[1]) return 2'b10;
    return 2'b00;
  endfunction

  // word touched by beat n of a burst
  function automatic int m_word(input logic [63:0] a, input logic [2:0] size,
                                input logic [1:0] burst, input int n);
    logic [63:0] ba;
    if (burst == BURST_FIXED && m_resp(a, size, burst) != 2'b10) ba = a;
    else ba = a + 64'(n) * (64'd1 << size);
    return int'(((ba - BASE) >> 3) % 64'(DEPTH));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      bq.delete();
    end else begin
      if (bus.r_valid) begin
        if (rq.size() == 0) chk("r_unexpected_valid", 64'(bus.r_valid), 64'd0);
        else begin
          chk("r_data", bus.r_data, rq[0].data);
          chk("r_resp", 64'(bus.r_resp), 64'(rq[0].resp));
          chk("r_last", 64'(bus.r_last), 64'(rq[0].last));
          chk("r_id",   64'(bus.r_id),   64'(rq[0].id));
          if (bus.r_ready) void'(rq.pop_front());
        end
      end
      if (bus.b_valid) begin
        if (bq.size() == 0) chk("b_unexpected_valid", 64'(bus.b_valid), 64'd0);
        else begin
          chk("b_id",   64'(bus.b_id),   64'(bq[0][5:2]));
          chk("b_resp", 64'(bus.b_resp), 64'(bq[0][1:0]));
          if (bus.b_ready) void'(bq.pop_front());
        end
      end
    end
  end

  // ---------------- transaction tasks ----------------
  logic [63:0] wd[$];
  logic [7:0]  ws[$];
  logic        wl[$];
  logic [1:0]  got_b;

  task automatic axi_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] r;
    int t;
    r = m_resp(addr, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      int w;
      w = m_word(addr, size, burst, i);
      if (r == 2'b00)
        for (int b = 0; b < 8; b++) if (ws[i][b]) mem_m[w][8*b +: 8] = wd[i][8*b +: 8];
      if ((wl[i] != (i == int'(len))) && r != 2'b11) r = 2'b10;
    end
    bq.push_back({id, r});
    bus.aw_addr = addr; bus.aw_id = id; bus.aw_len = len;
    bus.aw_size = size; bus.aw_burst = burst; bus.aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.aw_ready && t < 100);
    chk("aw_handshake", 64'(bus.aw_ready), 64'd1);
    @(posedge clk); #1 bus.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = wl[i]; bus.w_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.w_ready && t < 100);
      chk("w_handshake", 64'(bus.w_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    bus.b_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.b_valid && t < 100);
    chk("b_latency", 64'(t), 64'd1);
    got_b = bus.b_resp;
    @(posedge clk); #1 bus.b_ready = 1'b0;
  endtask

  logic [63:0] got_d[$];
  logic [1:0]  got_r[$];
  logic        got_l[$];
  logic [3:0]  got_i[$];

  task automatic axi_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_at, input int stall_n);
    logic [1:0] r;
    rexp_t e;
    int t, beats, stalled, exp_t;
    r = m_resp(addr, size, burst);
    got_d.delete(); got_r.delete(); got_l.delete(); got_i.delete();
    for (int i = 0; i <= int'(len); i++) begin
      e.data = (r == 2'b11) ? 64'd0 : mem_m[m_word(addr, size, burst, i)];
      e.resp = r; e.last = (i == int'(len)); e.id = id;
      rq.push_back(e);
    end
    bus.ar_addr = addr; bus.ar_id = id; bus.ar_len = len;
    bus.ar_size = size; bus.ar_burst = burst; bus.ar_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ar_ready && t < 100);
    chk("ar_handshake", 64'(bus.ar_ready), 64'd1);
    @(posedge clk); #1 bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
    t = 0; beats = 0; stalled = 0;
    while (beats <= int'(len) && t < 4000) begin
      @(negedge clk); t++;
      if (bus.r_valid && bus.r_ready) begin
        got_d.push_back(bus.r_data); got_r.push_back(bus.r_resp);
        got_l.push_back(bus.r_last); got_i.push_back(bus.r_id);
        beats++;
      end
      @(posedge clk); #1;
      if (beats == stall_at && stalled < stall_n) begin bus.r_ready = 1'b0; stalled++; end
      else bus.r_ready = 1'b1;
    end
    bus.r_ready = 1'b0;
    chk("r_beats", 64'(beats), 64'(int'(len) + 1));
`ifdef AXI_SLAVE_RD_WAIT_EN
    exp_t = (int'(len) + 1) * (LAT + 1);
`else
    exp_t = int'(len) + 1;
`endif
    if (stall_n == 0) chk("r_timing", 64'(t), 64'(exp_t));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rexp_t e;
    int beats, t;
    bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_id = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_id = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
    bus.r_ready = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_w_ready",  64'(bus.w_ready),  64'd0);
    chk("rst_b_valid",  64'(bus.b_valid),  64'd0);
    chk("rst_r_valid",  64'(bus.r_valid),  64'd0);
    chk("rst_r_data",   bus.r_data,        64'd0);
    chk("rst_resp_id",  64'({bus.r_resp, bus.b_resp, bus.r_id, bus.b_id}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ar_ready", 64'(bus.ar_ready), 64'd1);
    chk("idle_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("idle_w_ready",  64'(bus.w_ready),  64'd0);
    @(posedge clk); #1;

    // preload words 0..15; word 1 starts at zero
    wd.delete(); ws.delete(); wl.delete();
    for (int i = 0; i < 16; i++) begin
      wd.push_back((i == 1) ? 64'd0 : (64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0001_0001_0001)));
      ws.push_back(8'hFF); wl.push_back(i == 15);
    end
    axi_write(BASE, 4'h1, 8'd15, 3'd3, BURST_INCR);
    chk("fill_bresp", 64'(got_b), 64'd0);

    // partial-strobe single write then read-back
    wd = '{64'h1122_3344_5566_7788}; ws = '{8'h0F}; wl = '{1'b1};
    axi_write(BASE + 64'h8, 4'h2, 8'd0, 3'd3, BURST_INCR);
    chk("strb_bresp", 64'(got_b), 64'd0);
    axi_read(BASE + 64'h8, 4'h3, 8'd0, 3'd3, BURST_INCR, -1, 0);
    chk("strb_readback", got_d[0], 64'h0000_0000_5566_7788);
    chk("strb_rlast", 64'(got_l[0]), 64'd1);

    // four-beat INCR burst
    axi_read(BASE, 4'h5, 8'd3, 3'd3, BURST_INCR, -1, 0);
    chk("burst_id", 64'(got_i[3]), 64'h5);
    chk("burst_last_pattern", 64'({got_l[0], got_l[1], got_l[2], got_l[3]}), 64'b0001);
    chk("burst_beat2", got_d[2], 64'hA5A5_0002_0002_0002);

    // master backpressure mid-burst
    axi_read(BASE, 4'h6, 8'd5, 3'd3, BURST_INCR, 2, 3);
    // narrow INCR: 4-byte steps hit words 0,0,1,1
    axi_read(BASE, 4'h7, 8'd3, 3'd2, BURST_INCR, -1, 0);
    chk("narrow_beat3", got_d[3], 64'h0000_0000_5566_7788);
    // FIXED burst repeats one word
    axi_read(BASE + 64'h10, 4'h8, 8'd2, 3'd3, BURST_FIXED, -1, 0);
    // oversize and WRAP bursts
    axi_read(BASE, 4'h9, 8'd1, 3'd4, BURST_INCR, -1, 0);
    chk("oversize_resp", 64'(got_r[0]), 64'h2);
    axi_read(BASE + 64'h8, 4'hA, 8'd1, 3'd3, BURST_WRAP, -1, 0);
    chk("wrap_resp", 64'(got_r[1]), 64'h2);

    // out-of-range
    axi_read(64'h7000_0000, 4'hB, 8'd0, 3'd3, BURST_INCR, -1, 0);
    chk("decerr_rresp", 64'(got_r[0]), 64'h3);
    chk("decerr_rdata", got_d[0], 64'd0);
    wd = '{64'hDEAD_BEEF_DEAD_BEEF}; ws = '{8'hFF}; wl = '{1'b1};
    axi_write(64'h7000_0000, 4'hB, 8'd0, 3'd3, BURST_INCR);
    chk("decerr_bresp", 64'(got_b), 64'h3);
    axi_read(BASE, 4'h1, 8'd0, 3'd3, BURST_INCR, -1, 0);
    chk("decerr_no_write", got_d[0], 64'hA5A5_0000_0000_0000);

    // early w_last: both counted beats accepted, SLVERR returned
    wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}; ws = '{8'hFF, 8'hFF}; wl = '{1'b1, 1'b1};
    axi_write(BASE + 64'h100, 4'hC, 8'd1, 3'd3, BURST_INCR);
    chk("wlast_bresp", 64'(got_b), 64'h2);

    // word index wraps at the top of the array
    wd = '{64'h0BAD_F00D_CAFE_0001}; ws = '{8'hFF}; wl = '{1'b1};
    axi_write(BASE + 64'(DEPTH - 1) * 64'd8, 4'h4, 8'd0, 3'd3, BURST_INCR);
    axi_read(BASE + 64'(DEPTH - 1) * 64'd8, 4'h4, 8'd1, 3'd3, BURST_INCR, -1, 0);
    chk("depth_wrap_beat0", got_d[0], 64'h0BAD_F00D_CAFE_0001);
    chk("depth_wrap_beat1", got_d[1], 64'hA5A5_0000_0000_0000);

    // reset while beat 3 of an 8-beat read is pending
    for (int i = 0; i < 8; i++) begin
      e.data = mem_m[m_word(BASE, 3'd3, BURST_INCR, i)];
      e.resp = 2'b00; e.last = (i == 7); e.id = 4'hD;
      rq.push_back(e);
    end
    bus.ar_addr = BASE; bus.ar_id = 4'hD; bus.ar_len = 8'd7;
    bus.ar_size = 3'd3; bus.ar_burst = BURST_INCR; bus.ar_valid = 1'b1;
    @(negedge clk);
    chk("rstseq_ar_ready", 64'(bus.ar_ready), 64'd1);
    @(posedge clk); #1 bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
    beats = 0; t = 0;
    do begin
      @(negedge clk); t++;
      if (bus.r_valid && bus.r_ready) beats++;
      @(posedge clk); #1;
    end while (beats < 3 && t < 100);
    rst = 1'b1; bus.r_ready = 1'b0;
    @(negedge clk);
    chk("rstseq_beat3_pending", 64'(bus.r_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstseq_r_valid", 64'(bus.r_valid), 64'd0);
    chk("rstseq_ar_ready_after", 64'(bus.ar_ready), 64'd1);
    bus.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.r_ready = 1'b0;

    axi_read(BASE, 4'hE, 8'd7, 3'd3, BURST_INCR, -1, 0);
    chk("post_rst_beat5", got_d[5], 64'hA5A5_0005_0005_0005);

    repeat (4) @(posedge clk);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
